// File: rtl/register_file_if.sv
// Register-file bus: two read ports, one write port, a debug read port and the write counter.
interface register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] A1;
    logic [ADDR_WIDTH-1:0] A2;
    logic [ADDR_WIDTH-1:0] A3;
    logic                  WE3;
    logic [DATA_WIDTH-1:0] WD3;
    logic [DATA_WIDTH-1:0] RD1;
    logic [DATA_WIDTH-1:0] RD2;
    logic [ADDR_WIDTH-1:0] DbgAddr;
    logic [DATA_WIDTH-1:0] DbgData;
    logic [15:0]           WrCount;

    modport master (
        output A1, A2, A3, WE3, WD3, DbgAddr,
        input  RD1, RD2, DbgData, WrCount
    );

    modport slave (
        input  A1, A2, A3, WE3, WD3, DbgAddr,
        output RD1, RD2, DbgData, WrCount
    );
endinterface

// File: rtl/register_file.sv
// MIPS general-purpose register file: r0 hard-wired to zero, two combinational read ports,
// one synchronous write port. Optional write-to-read forwarding under macro REGFILE_BYPASS_EN.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic            clk,
    input  logic            rst,
    register_file_if.slave  bus
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];
    logic [15:0]           wr_count;
    logic                  write_hit;

    function automatic logic [15:0] sat_inc(input logic [15:0] count);
        return (count == 16'hFFFF) ? count : count + 16'd1;
    endfunction

    assign write_hit   = bus.WE3 && (bus.A3 != '0);
    assign bus.WrCount = wr_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wr_count <= '0;
        end else if (write_hit) begin
            regs[bus.A3] <= bus.WD3;
            wr_count     <= sat_inc(wr_count);
        end
    end

    // Reads are forced to zero while reset is held, so no stale value leaks out.
    always_comb begin
        bus.RD1 = '0;
        if (!rst && bus.A1 != '0) begin
            bus.RD1 = regs[bus.A1];
        end
`ifdef REGFILE_BYPASS_EN
        if (!rst && write_hit && bus.A3 == bus.A1) begin
            bus.RD1 = bus.WD3;
        end
`endif
    end

    always_comb begin
        bus.RD2 = '0;
        if (!rst && bus.A2 != '0) begin
            bus.RD2 = regs[bus.A2];
        end
`ifdef REGFILE_BYPASS_EN
        if (!rst && write_hit && bus.A3 == bus.A2) begin
            bus.RD2 = bus.WD3;
        end
`endif
    end

    // The debug port always shows committed storage, never the forwarded value.
    always_comb begin
        bus.DbgData = '0;
        if (!rst && bus.DbgAddr != '0) begin
            bus.DbgData = regs[bus.DbgAddr];
        end
    end
endmodule
